board_move_ctrl: RTL and testbench

- Owns the 256-bit checkers board state that feeds the board renderer.
- Accepts move requests from the game front end through a valid/ready handshake and checks them against checkers rules.
- On a legal move it updates the board buffer, including removing captured pieces and crowning kings, then alternates turns.
- Tracks piece counts and game-over, and reports each outcome with a one-cycle response.

---
 rtl/board_pkg.sv | 40 ++++
 rtl/board_move_ctrl_move_checker.sv | 70 +++++++
 rtl/board_move_ctrl.sv | 167 ++++++++++++++++
 tb/tb_board_move_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : board_pkg
//  Purpose  : Shared checkers-board definitions (nibble layout, response
//             codes, controller states, initial board, square indexing).
//             Also used by the board renderer.
//  Revision : 1.0 - initial release
// ============================================================================
package board_pkg;

  // Bit positions inside a 4-bit square nibble (bit3 is reserved, always 0)
  localparam int BIT_OCC  = 0;
  localparam int BIT_RED  = 1;
  localparam int BIT_KING = 2;

  // Move response codes
  localparam logic [1:0] RESP_STEP    = 2'b00;
  localparam logic [1:0] RESP_CAPTURE = 2'b01;
  localparam logic [1:0] RESP_ILLEGAL = 2'b10;
  localparam logic [1:0] RESP_OVER    = 2'b11;

  // Controller states
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_CHECK = 2'd1;
  localparam fsm_state_t ST_EXEC  = 2'd2;
  localparam fsm_state_t ST_RESP  = 2'd3;

  // Start position: red men on rows 0-2, green men on rows 5-7, dark squares
  // only. Written row 7 first, each row as col7..col0.
  localparam logic [255:0] INIT_BOARD =
    256'h10101010_01010101_10101010_00000000_00000000_03030303_30303030_03030303;

  // Square number; the nibble for a square starts at bit 4*sq_idx
  function automatic logic [5:0] sq_idx(input logic [2:0] col, input logic [2:0] row);
    return {row, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_move_ctrl_move_checker.sv
`default_nettype none
// ============================================================================
//  Module   : move_checker
//  Purpose  : Combinational legality check of one checkers move against the
//             current board; also reports capture, midpoint and promotion.
//  Revision : 1.0 - initial release
// ============================================================================
module move_checker
  import board_pkg::*;
#(
  parameter bit PROMOTE_EN = 1'b1
) (
  input  logic [255:0] board,
  input  logic [2:0]   from_col,
  input  logic [2:0]   from_row,
  input  logic [2:0]   to_col,
  input  logic [2:0]   to_row,
  input  logic         turn,
  output logic         legal,
  output logic         is_capture,
  output logic [5:0]   mid_idx,
  output logic         promote
);

  logic [5:0] from_idx;
  logic [5:0] to_idx;
  logic [3:0] dr;       // two's complement, bit3 is the sign
  logic [3:0] dc;
  logic [3:0] adr;
  logic [3:0] adc;
  logic [2:0] mid_col;
  logic [2:0] mid_row;
  logic       src_occ, src_red, src_king;
  logic       dst_occ;
  logic       mid_occ, mid_red;
  logic       geom_ok, dir_ok, jump_ok;

  assign from_idx = sq_idx(from_col, from_row);
  assign to_idx   = sq_idx(to_col, to_row);

  assign dr  = {1'b0, to_row} - {1'b0, from_row};
  assign dc  = {1'b0, to_col} - {1'b0, from_col};
  assign adr = dr[3] ? (4'd0 - dr) : dr;
  assign adc = dc[3] ? (4'd0 - dc) : dc;

  // Midpoint of a jump is one square from the source along each delta's sign
  assign mid_col = from_col + {dc[3], dc[3], 1'b1};
  assign mid_row = from_row + {dr[3], dr[3], 1'b1};
  assign mid_idx = sq_idx(mid_col, mid_row);

  assign src_occ  = board[{from_idx, 2'(BIT_OCC)}];
  assign src_red  = board[{from_idx, 2'(BIT_RED)}];
  assign src_king = board[{from_idx, 2'(BIT_KING)}];
  assign dst_occ  = board[{to_idx, 2'(BIT_OCC)}];
  assign mid_occ  = board[{mid_idx, 2'(BIT_OCC)}];
  assign mid_red  = board[{mid_idx, 2'(BIT_RED)}];

  // Diagonal of length 1 or 2 (this also rejects source == destination)
  assign geom_ok    = (adr == adc) && ((adr == 4'd1) || (adr == 4'd2));
  assign is_capture = (adr == 4'd2);
  // Men advance only: red towards row 7, green towards row 0
  assign dir_ok     = src_king || (turn ? !dr[3] : dr[3]);
  assign jump_ok    = !is_capture || (mid_occ && (mid_red != turn));

  assign legal = src_occ && (src_red == turn) && !dst_occ && geom_ok && dir_ok && jump_ok;

  assign promote = PROMOTE_EN && (turn ? (to_row == 3'd7) : (to_row == 3'd0));

endmodule
`default_nettype wire

// File: rtl/board_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : board_move_ctrl
//  Purpose  : Owns the checkers board buffer, accepts moves over valid/ready,
//             validates and applies them, tracks counts, turn and game over.
//  Revision : 1.0 - initial release
// ============================================================================
module board_move_ctrl
  import board_pkg::*;
#(
  parameter logic FIRST_TURN = 1'b1,
  parameter bit   PROMOTE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         new_game,
  input  logic         move_valid,
  output logic         move_ready,
  input  logic [2:0]   from_col,
  input  logic [2:0]   from_row,
  input  logic [2:0]   to_col,
  input  logic [2:0]   to_row,
  output logic         resp_valid,
  output logic [1:0]   resp_code,
  output logic [255:0] board_buffer,
  output logic         turn,
  output logic [3:0]   red_count,
  output logic [3:0]   green_count,
  output logic         game_over,
  output logic         winner
);

  fsm_state_t   state;
  logic [2:0]   fc_q, fr_q, tc_q, tr_q;
  logic [255:0] board;
  logic         turn_q;
  logic [3:0]   red_cnt, green_cnt;
  logic         over_q, winner_q;
  logic [1:0]   code_q;

  logic         legal, is_capture, promote;
  logic [5:0]   mid_idx;
  logic [5:0]   from_idx, to_idx;
  logic [2:0]   moved;
  logic [255:0] board_next;
  logic [3:0]   opp_cnt, opp_cnt_next;

  move_checker #(
    .PROMOTE_EN (PROMOTE_EN)
  ) u_checker (
    .board      (board),
    .from_col   (fc_q),
    .from_row   (fr_q),
    .to_col     (tc_q),
    .to_row     (tr_q),
    .turn       (turn_q),
    .legal      (legal),
    .is_capture (is_capture),
    .mid_idx    (mid_idx),
    .promote    (promote)
  );

  assign from_idx = sq_idx(fc_q, fr_q);
  assign to_idx   = sq_idx(tc_q, tr_q);
  assign moved    = board[{from_idx, 2'b00} +: 3];

  // Opponent of the mover loses a piece on a capture; never wraps below 0
  assign opp_cnt      = turn_q ? green_cnt : red_cnt;
  assign opp_cnt_next = (opp_cnt == 4'd0) ? 4'd0 : (opp_cnt - 4'd1);

  // Board after the latched move: piece relocated, jumped piece removed, crown applied
  always_comb begin
    board_next = board;
    board_next[{from_idx, 2'b00} +: 4] = 4'b0000;
    if (is_capture) begin
      board_next[{mid_idx, 2'b00} +: 4] = 4'b0000;
    end
    board_next[{to_idx, 2'b00} +: 4] = {1'b0, moved[BIT_KING] | promote, moved[BIT_RED], moved[BIT_OCC]};
  end

  // Move sequencing; new_game reloads everything and drops any move in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      board     <= INIT_BOARD;
      turn_q    <= FIRST_TURN;
      red_cnt   <= 4'd12;
      green_cnt <= 4'd12;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
      code_q    <= RESP_STEP;
      fc_q      <= 3'd0;
      fr_q      <= 3'd0;
      tc_q      <= 3'd0;
      tr_q      <= 3'd0;
    end else if (new_game) begin
      state     <= ST_IDLE;
      board     <= INIT_BOARD;
      turn_q    <= FIRST_TURN;
      red_cnt   <= 4'd12;
      green_cnt <= 4'd12;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
      code_q    <= RESP_STEP;
    end else begin
      case (state)
        ST_IDLE: begin
          if (move_valid) begin
            fc_q  <= from_col;
            fr_q  <= from_row;
            tc_q  <= to_col;
            tr_q  <= to_row;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (over_q) begin
            code_q <= RESP_OVER;
            state  <= ST_RESP;
          end else if (legal) begin
            state  <= ST_EXEC;
          end else begin
            code_q <= RESP_ILLEGAL;
            state  <= ST_RESP;
          end
        end
        ST_EXEC: begin
          board <= board_next;
          if (is_capture) begin
            if (turn_q) begin
              green_cnt <= opp_cnt_next;
            end else begin
              red_cnt <= opp_cnt_next;
            end
            if (opp_cnt_next == 4'd0) begin
              over_q   <= 1'b1;
              winner_q <= turn_q;
            end
            code_q <= RESP_CAPTURE;
          end else begin
            code_q <= RESP_STEP;
          end
          turn_q <= ~turn_q;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign move_ready   = (state == ST_IDLE);
  assign resp_valid   = (state == ST_RESP);
  assign resp_code    = code_q;
  assign board_buffer = board;
  assign turn         = turn_q;
  assign red_count    = red_cnt;
  assign green_count  = green_cnt;
  assign game_over    = over_q;
  assign winner       = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_board_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_move_ctrl
//  Purpose  : Self-checking bench for board_move_ctrl. A square-array game
//             model supplies expected outputs, compared on every falling edge;
//             hand-computed literals pin the model at key points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_board_move_ctrl;

  localparam logic FIRST_TURN = 1'b1;
  localparam bit   PROMOTE_EN = 1'b1;
  localparam logic [255:0] INIT_LIT =
    256'h10101010_01010101_10101010_00000000_00000000_03030303_30303030_03030303;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         new_game;
  logic         move_valid;
  logic         move_ready;
  logic [2:0]   from_col, from_row, to_col, to_row;
  logic         resp_valid;
  logic [1:0]   resp_code;
  logic [255:0] board_buffer;
  logic         turn;
  logic [3:0]   red_count, green_count;
  logic         game_over;
  logic         winner;

  board_move_ctrl #(
    .FIRST_TURN (FIRST_TURN),
    .PROMOTE_EN (PROMOTE_EN)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .new_game     (new_game),
    .move_valid   (move_valid),
    .move_ready   (move_ready),
    .from_col     (from_col),
    .from_row     (from_row),
    .to_col       (to_col),
    .to_row       (to_row),
    .resp_valid   (resp_valid),
    .resp_code    (resp_code),
    .board_buffer (board_buffer),
    .turn         (turn),
    .red_count    (red_count),
    .green_count  (green_count),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  // ---------------- game model: mb[col][row] holds a square nibble ----------
  logic [3:0] mb [0:7][0:7];
  int         m_red, m_green;
  logic       m_turn, m_go, m_win;
  logic       exp_ready, exp_rv;
  logic [1:0] exp_code;
  logic       chk_en;
  int         n_vec  = 0;
  int         n_fail = 0;
  logic [255:0] preload;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] v = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        v[4*(c + 8*r) +: 4] = mb[c][r];
    return v;
  endfunction

  task automatic model_init();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        mb[c][r] = 4'b0000;
        if ((c + r) % 2 == 0) begin
          if (r <= 2) mb[c][r] = 4'b0011;
          else if (r >= 5) mb[c][r] = 4'b0001;
        end
      end
    m_red = 12; m_green = 12; m_turn = FIRST_TURN; m_go = 1'b0; m_win = 1'b0;
    exp_ready = 1'b1; exp_rv = 1'b0; exp_code = 2'b00;
  endtask

  // Outcome per the game rules: 0 step, 1 capture, 2 illegal, 3 game over
  task automatic model_eval(input int fc, input int fr, input int tc, input int tr, output int code);
    logic [3:0] s, d, m;
    int  dr, dc, adr, adc;
    bit  ok;
    s = mb[fc][fr]; d = mb[tc][tr];
    dr = tr - fr; dc = tc - fc;
    adr = (dr < 0) ? -dr : dr;
    adc = (dc < 0) ? -dc : dc;
    ok = s[0] && (s[1] == m_turn) && !d[0] && (adr == adc) && (adr == 1 || adr == 2);
    if (ok && !s[2]) ok = m_turn ? (dr > 0) : (dr < 0);
    if (ok && adr == 2) begin
      m = mb[(fc + tc) / 2][(fr + tr) / 2];
      ok = m[0] && (m[1] != m_turn);
    end
    if (m_go) code = 3;
    else if (!ok) code = 2;
    else code = (adr == 2) ? 1 : 0;
  endtask

  task automatic model_commit(input int fc, input int fr, input int tc, input int tr);
    logic [3:0] p;
    int adr;
    p = mb[fc][fr];
    adr = (tr > fr) ? tr - fr : fr - tr;
    mb[fc][fr] = 4'b0000;
    if (adr == 2) begin
      mb[(fc + tc) / 2][(fr + tr) / 2] = 4'b0000;
      if (m_turn) begin if (m_green > 0) m_green--; end
      else begin if (m_red > 0) m_red--; end
      if ((m_turn ? m_green : m_red) == 0) begin m_go = 1'b1; m_win = m_turn; end
    end
    if (PROMOTE_EN && ((p[1] && tr == 7) || (!p[1] && tr == 0))) p[2] = 1'b1;
    mb[tc][tr] = p;
    m_turn = !m_turn;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("board_buffer", board_buffer, model_flat());
      check("turn", turn, m_turn);
      check("red_count", red_count, m_red);
      check("green_count", green_count, m_green);
      check("game_over", game_over, m_go);
      check("winner", winner, m_win);
      check("move_ready", move_ready, exp_ready);
      check("resp_valid", resp_valid, exp_rv);
      if (exp_rv) check("resp_code", resp_code, exp_code);
    end
  end

  // ---------------- drivers (start and end just after a rising edge) --------
  // abort: 0 none, 1 new_game in CHECK, 2 new_game in EXEC, 3 reset_n in EXEC
  task automatic do_move(input int fc, input int fr, input int tc, input int tr,
                         input int want, input int abort);
    int code;
    from_col = 3'(fc); from_row = 3'(fr); to_col = 3'(tc); to_row = 3'(tr);
    move_valid = 1'b1;
    model_eval(fc, fr, tc, tr, code);
    check("model_code", code, want);
    @(posedge clk); #1;                       // T+1: CHECK
    move_valid = 1'b0;
    exp_ready = 1'b0;
    if (abort == 1) begin
      new_game = 1'b1;
      @(posedge clk); #1;
      new_game = 1'b0;
      model_init();
      check("abort_check_board", board_buffer, INIT_LIT);
      return;
    end
    @(posedge clk); #1;                       // T+2: EXEC or RESP
    if (code >= 2) begin
      exp_rv = 1'b1; exp_code = 2'(code);
      @(posedge clk); #1;
      exp_rv = 1'b0; exp_ready = 1'b1;
      return;
    end
    if (abort == 2) begin
      new_game = 1'b1;
      @(posedge clk); #1;
      new_game = 1'b0;
      model_init();
      check("abort_exec_board", board_buffer, INIT_LIT);
      check("abort_exec_no_resp", resp_valid, 1'b0);
      return;
    end
    if (abort == 3) begin
      reset_n = 1'b0;
      model_init();
      #1;
      check("reset_async_board", board_buffer, INIT_LIT);
      check("reset_async_ready", move_ready, 1'b1);
      check("reset_async_code", resp_code, 2'b00);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;                       // T+3: board updated, resp_valid
    model_commit(fc, fr, tc, tr);
    exp_rv = 1'b1; exp_code = 2'(code);
    @(posedge clk); #1;                       // T+4: ready again
    exp_rv = 1'b0; exp_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; new_game = 1'b0; move_valid = 1'b0; chk_en = 1'b0;
    from_col = 3'd0; from_row = 3'd0; to_col = 3'd0; to_row = 3'd0;
    model_init();
    #1 reset_n = 1'b0;
    #2;
    chk_en = 1'b1;
    check("init_model_literal", model_flat(), INIT_LIT);
    check("reset_board", board_buffer, INIT_LIT);
    check("reset_turn", turn, 1'b1);
    check("reset_counts", {red_count, green_count}, 8'hCC);
    check("reset_resp_code", resp_code, 2'b00);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Red step, green step, red capture
    do_move(2, 2, 3, 3, 0, 0);
    check("step_src_nibble", board_buffer[75:72], 4'b0000);
    check("step_dst_nibble", board_buffer[111:108], 4'b0011);
    check("step_turn", turn, 1'b0);
    check("step_ready_t4", move_ready, 1'b1);
    do_move(5, 5, 4, 4, 0, 0);
    do_move(3, 3, 5, 5, 1, 0);
    check("cap_mid_nibble", board_buffer[147:144], 4'b0000);
    check("cap_dst_nibble", board_buffer[183:180], 4'b0011);
    check("cap_green_count", green_count, 4'd11);

    // Illegal requests (green to move first)
    do_move(4, 2, 3, 3, 2, 0);   // wrong player's piece
    do_move(6, 6, 7, 5, 2, 0);   // destination occupied
    do_move(7, 5, 6, 4, 0, 0);   // legal green step
    do_move(5, 5, 4, 4, 2, 0);   // red man backward
    do_move(0, 2, 2, 4, 2, 0);   // jump over empty midpoint
    do_move(3, 3, 4, 4, 2, 0);   // empty source
    do_move(4, 2, 4, 2, 2, 0);   // source equals destination
    do_move(4, 2, 7, 5, 2, 0);   // three-square diagonal
    check("illegal_turn_kept", turn, 1'b1);

    // Aborts
    do_move(4, 2, 3, 3, 0, 1);   // new_game during CHECK
    do_move(2, 2, 3, 3, 0, 0);
    do_move(5, 5, 4, 4, 0, 0);
    do_move(3, 3, 5, 5, 1, 2);   // new_game during EXEC
    do_move(2, 2, 3, 3, 0, 0);
    from_col = 3'd5; from_row = 3'd5; to_col = 3'd4; to_row = 3'd4;
    move_valid = 1'b1; new_game = 1'b1;      // same-cycle handshake is dropped
    @(posedge clk); #1;
    move_valid = 1'b0; new_game = 1'b0;
    model_init();
    check("ng_handshake_ready", move_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    do_move(2, 2, 3, 3, 0, 3);   // reset_n during EXEC

    // Promotion and game over from a preloaded endgame (red to move)
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mb[c][r] = 4'b0000;
    mb[2][6] = 4'b0011;
    mb[5][7] = 4'b0001;
    m_red = 1; m_green = 1;
    preload = model_flat();
    force dut.board = preload;
    force dut.red_cnt = 4'd1;
    force dut.green_cnt = 4'd1;
    #1;
    release dut.board;
    release dut.red_cnt;
    release dut.green_cnt;
    do_move(2, 6, 3, 7, 0, 0);
    check("promote_nibble", board_buffer[239:236], 4'b0111);
    do_move(5, 7, 4, 6, 0, 0);
    do_move(3, 7, 5, 5, 1, 0);   // king jumps backward over the last green piece
    check("over_flag", game_over, 1'b1);
    check("over_winner", winner, 1'b1);
    check("over_green_count", green_count, 4'd0);
    check("over_king_nibble", board_buffer[183:180], 4'b0111);
    do_move(5, 5, 6, 6, 3, 0);   // rejected: game over
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_init();
    check("newgame_over_clear", game_over, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
